// File: rtl/iq_cal_ctrl_if.sv
// rtl/iq_cal_ctrl_if.sv - control/debug bundle between iq_cal_ctrl (master) and iq_comp (slave)
interface iq_cal_ctrl_if #(
   parameter int W_WIDTH = 13
);
   logic [1:0]                op_mode;
   logic                      freeze_iqcomp;
   logic signed [W_WIDTH-1:0] Wr_store;
   logic signed [W_WIDTH-1:0] Wj_store;
   logic signed [W_WIDTH-1:0] Wr;
   logic signed [W_WIDTH-1:0] Wj;

   modport master (
      output op_mode, freeze_iqcomp, Wr_store, Wj_store,
      input  Wr, Wj
   );

   modport slave (
      input  op_mode, freeze_iqcomp, Wr_store, Wj_store,
      output Wr, Wj
   );
endinterface

// File: rtl/iq_cal_ctrl.sv
// rtl/iq_cal_ctrl.sv - iq_comp calibration sequencer: adapt, detect convergence, freeze, capture, apply
module iq_cal_ctrl #(
   parameter int W_WIDTH          = 13,
   parameter int CNT_WIDTH        = 16,
   parameter int STABLE_THRESH    = 8,
   parameter int STABLE_CYCLES    = 256,
   parameter int MAX_ADAPT_CYCLES = 40000
) (
   input  logic                       clk,
   input  logic                       RESET,
   input  logic                       cal_start,
   input  logic                       cal_abort,
   input  logic                       load_w,
   input  logic signed [W_WIDTH-1:0]  w_load_r,
   input  logic signed [W_WIDTH-1:0]  w_load_j,
   iq_cal_ctrl_if.master              iq,
   output logic                       cal_busy,
   output logic                       cal_done,
   output logic                       cal_fail,
   output logic [CNT_WIDTH-1:0]       adapt_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_ADAPT, S_FREEZE, S_CAPTURE, S_APPLY, S_FAIL
   } state_t;

   localparam logic [CNT_WIDTH-1:0]      CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0]      STABLE_LIM = CNT_WIDTH'(STABLE_CYCLES);
   localparam logic [CNT_WIDTH-1:0]      ADAPT_LIM  = CNT_WIDTH'(MAX_ADAPT_CYCLES);
   localparam logic signed [W_WIDTH:0]   THR        = (W_WIDTH+1)'(STABLE_THRESH);

   state_t                    state, state_n;
   logic                      clr_q, clr_n;
   logic                      first_q, first_n;
   logic signed [W_WIDTH-1:0] wr_prev, wj_prev, wr_prev_n, wj_prev_n;
   logic signed [W_WIDTH-1:0] wr_st_q, wj_st_q, wr_st_n, wj_st_n;
   logic [CNT_WIDTH-1:0]      stable_cnt, stable_n, adapt_n;
   logic [1:0]                op_mode_q, op_mode_n;
   logic                      freeze_q, freeze_n;
   logic                      busy_n, done_n, fail_n;
   logic signed [W_WIDTH:0]   d_r, d_j;
   logic                      is_stable;

   // One extra bit so a full-scale swing cannot alias into a small delta
   assign d_r = $signed({iq.Wr[W_WIDTH-1], iq.Wr}) - $signed({wr_prev[W_WIDTH-1], wr_prev});
   assign d_j = $signed({iq.Wj[W_WIDTH-1], iq.Wj}) - $signed({wj_prev[W_WIDTH-1], wj_prev});
   assign is_stable = (d_r >= -THR) && (d_r <= THR) && (d_j >= -THR) && (d_j <= THR);

   assign iq.op_mode       = op_mode_q;
   assign iq.freeze_iqcomp = freeze_q;
   assign iq.Wr_store      = wr_st_q;
   assign iq.Wj_store      = wj_st_q;

   always_comb begin
      state_n   = state;
      clr_n     = clr_q;
      first_n   = first_q;
      wr_prev_n = wr_prev;
      wj_prev_n = wj_prev;
      wr_st_n   = wr_st_q;
      wj_st_n   = wj_st_q;
      adapt_n   = adapt_cnt;
      stable_n  = stable_cnt;
      fail_n    = cal_fail;
      op_mode_n = 2'b00;
      freeze_n  = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;

      if (cal_abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (cal_start) begin
                  state_n = S_CLEAR;
               end else if (load_w) begin
                  wr_st_n = w_load_r;
                  wj_st_n = w_load_j;
                  state_n = S_APPLY;
               end
            end
            S_CLEAR: begin
               clr_n = 1'b1;
               if (clr_q) state_n = S_ADAPT;
            end
            S_ADAPT: begin
               wr_prev_n = iq.Wr;
               wj_prev_n = iq.Wj;
               first_n   = 1'b0;
               if (adapt_cnt != CNT_MAX) adapt_n = adapt_cnt + 1'b1;
               if (!first_q) begin
                  if (!is_stable)               stable_n = '0;
                  else if (stable_cnt != CNT_MAX) stable_n = stable_cnt + 1'b1;
               end
               // Convergence is checked first so it wins a same-cycle tie with the budget
               if (stable_n >= STABLE_LIM)    state_n = S_FREEZE;
               else if (adapt_n >= ADAPT_LIM) state_n = S_FAIL;
            end
            S_FREEZE:  state_n = S_CAPTURE;
            S_CAPTURE: begin
               wr_st_n = iq.Wr;
               wj_st_n = iq.Wj;
               state_n = S_APPLY;
            end
            S_APPLY, S_FAIL: begin
               if (cal_start) state_n = S_CLEAR;
            end
            default: state_n = S_IDLE;
         endcase
      end

      if (state_n == S_CLEAR && state != S_CLEAR) begin
         clr_n    = 1'b0;
         first_n  = 1'b1;
         adapt_n  = '0;
         stable_n = '0;
         fail_n   = 1'b0;
      end
      if (state_n == S_FAIL) fail_n = 1'b1;

      // Outputs decoded from the next state so they register in step with it
      case (state_n)
         S_CLEAR:   busy_n = 1'b1;
         S_ADAPT:   begin op_mode_n = 2'b01; busy_n = 1'b1; end
         S_FREEZE,
         S_CAPTURE: begin op_mode_n = 2'b01; freeze_n = 1'b1; busy_n = 1'b1; end
         S_APPLY:   begin op_mode_n = 2'b10; done_n = 1'b1; end
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state      <= S_IDLE;
         clr_q      <= 1'b0;
         first_q    <= 1'b0;
         wr_prev    <= '0;
         wj_prev    <= '0;
         wr_st_q    <= '0;
         wj_st_q    <= '0;
         stable_cnt <= '0;
         adapt_cnt  <= '0;
         op_mode_q  <= 2'b00;
         freeze_q   <= 1'b0;
         cal_busy   <= 1'b0;
         cal_done   <= 1'b0;
         cal_fail   <= 1'b0;
      end else begin
         state      <= state_n;
         clr_q      <= clr_n;
         first_q    <= first_n;
         wr_prev    <= wr_prev_n;
         wj_prev    <= wj_prev_n;
         wr_st_q    <= wr_st_n;
         wj_st_q    <= wj_st_n;
         stable_cnt <= stable_n;
         adapt_cnt  <= adapt_n;
         op_mode_q  <= op_mode_n;
         freeze_q   <= freeze_n;
         cal_busy   <= busy_n;
         cal_done   <= done_n;
         cal_fail   <= fail_n;
      end
   end

endmodule

// File: tb/tb_iq_cal_ctrl.sv
// tb/tb_iq_cal_ctrl.sv - randomized self-checking bench for iq_cal_ctrl against a sequence-level model
module tb_iq_cal_ctrl;
   localparam int W    = 13;
   localparam int THR  = 8;
   localparam int SCYC = 256;
   localparam int MAXA = 40000;

   // {op_mode, freeze, busy, done, fail}
   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_CLEAR = 6'b000100;
   localparam logic [5:0] O_ADAPT = 6'b010100;
   localparam logic [5:0] O_FRZ   = 6'b011100;
   localparam logic [5:0] O_APPLY = 6'b100010;
   localparam logic [5:0] O_FAIL  = 6'b000001;

   logic                clk = 1'b0;
   logic                RESET = 1'b1;
   logic                cal_start = 1'b0;
   logic                cal_abort = 1'b0;
   logic                load_w = 1'b0;
   logic signed [W-1:0] w_load_r = '0;
   logic signed [W-1:0] w_load_j = '0;
   logic                cal_busy, cal_done, cal_fail;
   logic [15:0]         adapt_cnt;

   iq_cal_ctrl_if #(.W_WIDTH(W)) iqb ();

   iq_cal_ctrl #(
      .W_WIDTH(W), .CNT_WIDTH(16), .STABLE_THRESH(THR),
      .STABLE_CYCLES(SCYC), .MAX_ADAPT_CYCLES(MAXA)
   ) dut (
      .clk(clk), .RESET(RESET), .cal_start(cal_start), .cal_abort(cal_abort),
      .load_w(load_w), .w_load_r(w_load_r), .w_load_j(w_load_j), .iq(iqb),
      .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail), .adapt_cnt(adapt_cnt)
   );

   always #5 clk = ~clk;

   wire [5:0] obs = {iqb.op_mode, iqb.freeze_iqcomp, cal_busy, cal_done, cal_fail};

   int n_cmp = 0;
   int n_err = 0;
   int wr_seq [0:MAXA];
   int wj_seq [0:MAXA];
   int exp_wr = 0;
   int exp_wj = 0;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Index of the ADAPT sample after which the sequencer must leave ADAPT (0 = still adapting)
   function automatic int model_end(input int n, output bit conv);
      int run = 0;
      conv = 1'b0;
      for (int j = 1; j <= n; j++) begin
         if (j > 1) begin
            if (iabs(wr_seq[j] - wr_seq[j-1]) <= THR && iabs(wj_seq[j] - wj_seq[j-1]) <= THR)
               run++;
            else
               run = 0;
         end
         if (run >= SCYC) begin
            conv = 1'b1;
            return j;
         end
         if (j >= MAXA) return j;
      end
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      cal_abort = 1'b1;
      step();
      cal_abort = 1'b0;
   endtask

   task automatic begin_cal();
      cal_start = 1'b1;
      step();
      cal_start = 1'b0;
      step();
      step();
   endtask

   task automatic drive_adapt(input int n, output int leave_j);
      leave_j = 0;
      for (int j = 1; j <= n; j++) begin
         iqb.Wr = W'(wr_seq[j]);
         iqb.Wj = W'(wj_seq[j]);
         step();
         if (obs !== O_ADAPT) begin
            leave_j = j;
            return;
         end
      end
   endtask

   task automatic finish_capture(input int cr, input int cj, output logic [5:0] o_cap, output logic [5:0] o_app);
      iqb.Wr = W'(cr);
      iqb.Wj = W'(cj);
      step();
      o_cap = obs;
      step();
      o_app = obs;
   endtask

   task automatic test_reset();
      #13;
      n_cmp++;
      if ({obs, iqb.Wr_store, iqb.Wj_store, adapt_cnt} !== {O_IDLE, 13'd0, 13'd0, 16'd0}) begin
         n_err++;
         $display("FAIL reset_values: got %b/%0d/%0d/%0d want %b/0/0/0", obs, iqb.Wr_store, iqb.Wj_store, adapt_cnt, O_IDLE);
      end
      step();
      RESET = 1'b0;
      step();
      n_cmp++;
      if (obs !== O_IDLE) begin
         n_err++;
         $display("FAIL reset_release_idle: got %b want %b", obs, O_IDLE);
      end
   endtask

   task automatic test_convergence();
      int lj, ej;
      bit conv;
      logic [5:0] oc, oa;
      for (int j = 1; j <= 400; j++) begin wr_seq[j] = 100; wj_seq[j] = -50; end
      ej = model_end(400, conv);
      cal_start = 1'b1;
      step();
      cal_start = 1'b0;
      n_cmp++;
      if (obs !== O_CLEAR) begin n_err++; $display("FAIL conv_clear1: got %b want %b", obs, O_CLEAR); end
      step();
      n_cmp++;
      if (obs !== O_CLEAR) begin n_err++; $display("FAIL conv_clear2: got %b want %b", obs, O_CLEAR); end
      step();
      n_cmp++;
      if (obs !== O_ADAPT) begin n_err++; $display("FAIL conv_adapt_entry: got %b want %b", obs, O_ADAPT); end
      drive_adapt(400, lj);
      n_cmp++;
      if (lj !== ej) begin n_err++; $display("FAIL conv_leave_cycle: got %0d want %0d", lj, ej); end
      n_cmp++;
      if (obs !== O_FRZ) begin n_err++; $display("FAIL conv_freeze: got %b want %b", obs, O_FRZ); end
      finish_capture(100, -50, oc, oa);
      n_cmp++;
      if (oc !== O_FRZ) begin n_err++; $display("FAIL conv_capture: got %b want %b", oc, O_FRZ); end
      n_cmp++;
      if ({oa, iqb.Wr_store, iqb.Wj_store} !== {O_APPLY, 13'sd100, -13'sd50}) begin
         n_err++;
         $display("FAIL conv_apply: got %b/%0d/%0d want %b/100/-50", oa, iqb.Wr_store, iqb.Wj_store, O_APPLY);
      end
      exp_wr = 100;
      exp_wj = -50;
   endtask

   task automatic test_reset_mid();
      #3;
      RESET = 1'b1;
      #1;
      n_cmp++;
      if ({obs, iqb.Wr_store, iqb.Wj_store, adapt_cnt} !== {O_IDLE, 13'd0, 13'd0, 16'd0}) begin
         n_err++;
         $display("FAIL reset_async_mid: got %b/%0d/%0d/%0d want %b/0/0/0", obs, iqb.Wr_store, iqb.Wj_store, adapt_cnt, O_IDLE);
      end
      #2;
      RESET = 1'b0;
      step();
      n_cmp++;
      if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_mid_idle: got %b want %b", obs, O_IDLE); end
      exp_wr = 0;
      exp_wj = 0;
   endtask

   task automatic test_threshold_pass();
      int lj, ej, cr, cj;
      bit conv;
      logic [5:0] oc, oa;
      for (int j = 1; j <= 400; j++) begin wr_seq[j] = -2000 + 8 * j; wj_seq[j] = 1500 - 8 * j; end
      ej = model_end(400, conv);
      begin_cal();
      drive_adapt(400, lj);
      n_cmp++;
      if ({lj, obs} !== {ej, O_FRZ}) begin
         n_err++;
         $display("FAIL thr8_converge: got %0d/%b want %0d/%b", lj, obs, ej, O_FRZ);
      end
      cr = int'($urandom_range(0, 8191)) - 4096;
      cj = int'($urandom_range(0, 8191)) - 4096;
      finish_capture(cr, cj, oc, oa);
      n_cmp++;
      if ({oc, oa, iqb.Wr_store, iqb.Wj_store} !== {O_FRZ, O_APPLY, W'(cr), W'(cj)}) begin
         n_err++;
         $display("FAIL thr8_capture: got %b/%b/%0d/%0d want %b/%b/%0d/%0d", oc, oa, iqb.Wr_store, iqb.Wj_store, O_FRZ, O_APPLY, cr, cj);
      end
      exp_wr = cr;
      exp_wj = cj;
      go_idle();
   endtask

   task automatic test_threshold_fail();
      int lj, ej, nx, d;
      bit conv;
      wr_seq[1] = 0;
      wj_seq[1] = int'($urandom_range(0, 2000)) - 1000;
      for (int j = 2; j <= MAXA; j++) begin
         d  = ($urandom_range(0, 1) == 1) ? 9 : -9;
         nx = wr_seq[j-1] + d;
         if (nx > 4095 || nx < -4096) nx = wr_seq[j-1] - d;
         wr_seq[j] = nx;
         wj_seq[j] = wj_seq[1];
      end
      ej = model_end(MAXA, conv);
      begin_cal();
      drive_adapt(MAXA, lj);
      n_cmp++;
      if ({lj, obs, adapt_cnt} !== {ej, O_FAIL, 16'(MAXA)}) begin
         n_err++;
         $display("FAIL thr9_budget: got %0d/%b/%0d want %0d/%b/%0d", lj, obs, adapt_cnt, ej, O_FAIL, MAXA);
      end
      n_cmp++;
      if ({iqb.Wr_store, iqb.Wj_store} !== {W'(exp_wr), W'(exp_wj)}) begin
         n_err++;
         $display("FAIL thr9_stores_kept: got %0d/%0d want %0d/%0d", iqb.Wr_store, iqb.Wj_store, exp_wr, exp_wj);
      end
   endtask

   task automatic test_fail_recovery();
      int lr, lw;
      go_idle();
      n_cmp++;
      if (obs !== 6'b000001) begin n_err++; $display("FAIL abort_from_fail: got %b want 000001", obs); end
      lr = int'($urandom_range(0, 8191)) - 4096;
      lw = int'($urandom_range(0, 8191)) - 4096;
      w_load_r = W'(lr);
      w_load_j = W'(lw);
      load_w = 1'b1;
      step();
      load_w = 1'b0;
      n_cmp++;
      if ({iqb.Wr_store, iqb.Wj_store} !== {W'(lr), W'(lw)}) begin
         n_err++;
         $display("FAIL load_after_fail: got %0d/%0d want %0d/%0d", iqb.Wr_store, iqb.Wj_store, lr, lw);
      end
      step();
      n_cmp++;
      if (obs !== 6'b100011) begin n_err++; $display("FAIL apply_fail_held: got %b want 100011", obs); end
      exp_wr = lr;
      exp_wj = lw;
      cal_start = 1'b1;
      step();
      cal_start = 1'b0;
      n_cmp++;
      if (obs !== O_CLEAR) begin n_err++; $display("FAIL restart_clears_fail: got %b want %b", obs, O_CLEAR); end
      go_idle();
   endtask

   task automatic test_extremes();
      int lj, ej;
      bit conv;
      wj_seq[1] = int'($urandom_range(0, 2000)) - 1000;
      for (int j = 1; j <= 600; j++) begin
         wr_seq[j] = (j % 2 == 1) ? 4095 : -4096;
         wj_seq[j] = wj_seq[1];
      end
      ej = model_end(600, conv);
      begin_cal();
      drive_adapt(600, lj);
      n_cmp++;
      if ({lj, adapt_cnt} !== {ej, 16'd600}) begin
         n_err++;
         $display("FAIL extremes_no_converge: got %0d/%0d want %0d/600", lj, adapt_cnt, ej);
      end
      go_idle();
   endtask

   task automatic test_abort();
      int lj;
      w_load_r = 13'sd20;
      w_load_j = 13'sd30;
      load_w = 1'b1;
      step();
      load_w = 1'b0;
      step();
      n_cmp++;
      if ({obs, iqb.Wr_store, iqb.Wj_store} !== {O_APPLY, 13'sd20, 13'sd30}) begin
         n_err++;
         $display("FAIL abort_preload: got %b/%0d/%0d want %b/20/30", obs, iqb.Wr_store, iqb.Wj_store, O_APPLY);
      end
      go_idle();
      for (int j = 1; j <= 500; j++) begin wr_seq[j] = (j % 2) * 100; wj_seq[j] = 0; end
      begin_cal();
      drive_adapt(500, lj);
      n_cmp++;
      if ({lj, adapt_cnt} !== {0, 16'd500}) begin
         n_err++;
         $display("FAIL abort_adapt_500: got %0d/%0d want 0/500", lj, adapt_cnt);
      end
      go_idle();
      n_cmp++;
      if ({obs, iqb.Wr_store, iqb.Wj_store} !== {O_IDLE, 13'sd20, 13'sd30}) begin
         n_err++;
         $display("FAIL abort_in_adapt: got %b/%0d/%0d want %b/20/30", obs, iqb.Wr_store, iqb.Wj_store, O_IDLE);
      end
      cal_start = 1'b1;
      cal_abort = 1'b1;
      step();
      cal_start = 1'b0;
      cal_abort = 1'b0;
      step();
      n_cmp++;
      if (obs !== O_IDLE) begin n_err++; $display("FAIL start_abort_together: got %b want %b", obs, O_IDLE); end
      exp_wr = 20;
      exp_wj = 30;
   endtask

   task automatic test_direct_load();
      int lj;
      w_load_r = 13'sd1;
      w_load_j = 13'sd1;
      load_w = 1'b1;
      cal_start = 1'b1;
      step();
      load_w = 1'b0;
      cal_start = 1'b0;
      n_cmp++;
      if ({obs, iqb.Wr_store, iqb.Wj_store} !== {O_CLEAR, W'(exp_wr), W'(exp_wj)}) begin
         n_err++;
         $display("FAIL start_beats_load: got %b/%0d/%0d want %b/%0d/%0d", obs, iqb.Wr_store, iqb.Wj_store, O_CLEAR, exp_wr, exp_wj);
      end
      go_idle();
      w_load_r = -13'sd7;
      w_load_j = 13'sd12;
      load_w = 1'b1;
      step();
      load_w = 1'b0;
      n_cmp++;
      if ({iqb.Wr_store, iqb.Wj_store} !== {-13'sd7, 13'sd12}) begin
         n_err++;
         $display("FAIL direct_load_stores: got %0d/%0d want -7/12", iqb.Wr_store, iqb.Wj_store);
      end
      step();
      n_cmp++;
      if (obs !== O_APPLY) begin n_err++; $display("FAIL direct_load_apply: got %b want %b", obs, O_APPLY); end
      begin_cal();
      for (int j = 1; j <= 20; j++) begin wr_seq[j] = (j % 2) * 50; wj_seq[j] = 0; end
      w_load_r = 13'sd555;
      w_load_j = -13'sd555;
      load_w = 1'b1;
      cal_start = 1'b1;
      drive_adapt(20, lj);
      load_w = 1'b0;
      cal_start = 1'b0;
      n_cmp++;
      if ({lj, adapt_cnt, iqb.Wr_store, iqb.Wj_store} !== {0, 16'd20, -13'sd7, 13'sd12}) begin
         n_err++;
         $display("FAIL load_start_ignored_busy: got %0d/%0d/%0d/%0d want 0/20/-7/12", lj, adapt_cnt, iqb.Wr_store, iqb.Wj_store);
      end
      go_idle();
      exp_wr = -7;
      exp_wj = 12;
   endtask

   task automatic test_random_walk();
      int lj, ej, cr, cj, nx, d;
      bit conv;
      logic [5:0] oc, oa;
      for (int it = 0; it < 3; it++) begin
         wr_seq[1] = int'($urandom_range(0, 6000)) - 3000;
         wj_seq[1] = int'($urandom_range(0, 6000)) - 3000;
         for (int j = 2; j <= 2500; j++) begin
            for (int c = 0; c < 2; c++) begin
               case ($urandom_range(0, 799))
                  0:       d = ($urandom_range(0, 1) == 1) ? 9 : -9;
                  1:       d = int'($urandom_range(10, 400)) * (($urandom_range(0, 1) == 1) ? 1 : -1);
                  default: d = int'($urandom_range(0, 16)) - 8;
               endcase
               nx = ((c == 0) ? wr_seq[j-1] : wj_seq[j-1]) + d;
               if (nx > 4095 || nx < -4096) nx = nx - 2 * d;
               if (c == 0) wr_seq[j] = nx; else wj_seq[j] = nx;
            end
         end
         ej = model_end(2500, conv);
         begin_cal();
         drive_adapt(2500, lj);
         n_cmp++;
         if (lj !== ej) begin n_err++; $display("FAIL rand%0d_leave: got %0d want %0d", it, lj, ej); end
         if (conv) begin
            cr = int'($urandom_range(0, 8191)) - 4096;
            cj = int'($urandom_range(0, 8191)) - 4096;
            finish_capture(cr, cj, oc, oa);
            n_cmp++;
            if ({oc, oa, iqb.Wr_store, iqb.Wj_store} !== {O_FRZ, O_APPLY, W'(cr), W'(cj)}) begin
               n_err++;
               $display("FAIL rand%0d_capture: got %b/%b/%0d/%0d want %b/%b/%0d/%0d", it, oc, oa, iqb.Wr_store, iqb.Wj_store, O_FRZ, O_APPLY, cr, cj);
            end
            exp_wr = cr;
            exp_wj = cj;
         end else begin
            n_cmp++;
            if ({obs, adapt_cnt} !== {O_ADAPT, 16'd2500}) begin
               n_err++;
               $display("FAIL rand%0d_still_adapt: got %b/%0d want %b/2500", it, obs, adapt_cnt, O_ADAPT);
            end
         end
         go_idle();
      end
   endtask

   initial begin
      iqb.Wr = '0;
      iqb.Wj = '0;
      test_reset();
      test_convergence();
      test_reset_mid();
      test_threshold_pass();
      test_threshold_fail();
      test_fail_recovery();
      test_extremes();
      test_abort();
      test_direct_load();
      test_random_walk();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

endmodule

// File: doc/iq_cal_ctrl.md
Name: iq_cal_ctrl

Overview:
- Calibration sequencer that drives the control side of iq_comp: op_mode, freeze_iqcomp and the external Wr_in/Wj_in coefficients.
- Runs internal W adaptation, detects convergence from the W debug outputs, freezes and captures W, then switches iq_comp to EXT_W using the captured values.
- Sits between the MCU register interface and iq_comp; also supports a direct MCU load of stored coefficients.

Parameters:
- W_WIDTH, 13, coefficient width; matches iq_comp Wr/Wj.
- CNT_WIDTH, 16, width of the adapt and stable counters.
- STABLE_THRESH, 8, maximum |delta W| per cycle that still counts as stable.
- STABLE_CYCLES, 256, number of consecutive stable cycles needed to declare convergence.
- MAX_ADAPT_CYCLES, 40000, adapt cycle budget before the sequence fails.

Ports:
- clk, in, 1: system clock.
- RESET, in, 1: asynchronous, active-high reset.
- cal_start, in, 1: pulse; starts a calibration.
- cal_abort, in, 1: pulse; returns the block to IDLE.
- load_w, in, 1: pulse; loads w_load_r/w_load_j and applies them.
- w_load_r, in, W_WIDTH signed: MCU-supplied Wr.
- w_load_j, in, W_WIDTH signed: MCU-supplied Wj.
- Wr, in, W_WIDTH signed: Wr debug output from iq_comp.
- Wj, in, W_WIDTH signed: Wj debug output from iq_comp.
- op_mode, out, 2: to iq_comp (00 BYPASS, 01 INT_W, 10 EXT_W).
- freeze_iqcomp, out, 1: to iq_comp.
- Wr_store, out, W_WIDTH signed: drives iq_comp Wr_in.
- Wj_store, out, W_WIDTH signed: drives iq_comp Wj_in.
- cal_busy, out, 1: high in CLEAR, ADAPT, FREEZE and CAPTURE.
- cal_done, out, 1: high in APPLY.
- cal_fail, out, 1: sticky fail flag.
- adapt_cnt, out, CNT_WIDTH: cycles spent in ADAPT (debug).

Behaviour:
- All outputs are registered.
- Reset (async, RESET=1): state IDLE, op_mode=00, freeze_iqcomp=0, Wr_store=Wj_store=0, all flags 0, all counters 0.
- IDLE: op_mode=00, freeze=0.
  - cal_start -> CLEAR.
  - load_w (with no cal_start) -> Wr_store/Wj_store <= w_load_r/w_load_j, then APPLY on the next cycle.
  - cal_start and load_w together: cal_start wins.
- CLEAR: op_mode=00 for exactly 2 cycles so iq_comp zeroes W. Clears cal_fail and adapt_cnt, then -> ADAPT.
- ADAPT: op_mode=01, freeze=0.
  - Each cycle, Wr_prev/Wj_prev <= Wr/Wj, and adapt_cnt increments, saturating at the max value.
  - Deltas dR = Wr - Wr_prev and dJ = Wj - Wj_prev are computed at W_WIDTH+1 bits, sign-extended, with no overflow.
  - The first ADAPT cycle only loads prev; no compare is made.
  - If |dR| <= STABLE_THRESH and |dJ| <= STABLE_THRESH, stable_cnt increments; otherwise stable_cnt <= 0. The boundary value equal to STABLE_THRESH counts as stable.
  - stable_cnt reaching STABLE_CYCLES -> FREEZE.
  - Otherwise, adapt_cnt reaching MAX_ADAPT_CYCLES -> FAIL.
  - If both conditions hit in the same cycle, convergence wins.
- FREEZE: op_mode=01, freeze=1, for 1 cycle to let the registered W settle. -> CAPTURE.
- CAPTURE: op_mode=01, freeze=1. Wr_store/Wj_store <= Wr/Wj. -> APPLY.
- APPLY: op_mode=10, freeze=0, cal_done=1. Stays until cal_start (-> CLEAR) or cal_abort (-> IDLE).
- FAIL: op_mode=00, cal_fail=1, Wr_store/Wj_store unchanged. cal_start -> CLEAR; cal_abort -> IDLE with cal_fail held.
- cal_abort in any state -> IDLE on the next edge.
  - Wr_store/Wj_store retain their last captured value.
  - cal_fail keeps its value.
  - cal_abort has priority over every other input.
- cal_start while cal_busy=1: ignored.
- load_w outside IDLE: ignored.
- Reset mid-sequence: immediate return to the reset values, including the stores.

Test Plan:
- Reset: assert RESET asynchronously mid-clock -> op_mode=00, stores=0, done/busy/fail=0 immediately, without waiting for a clock edge.
- Convergence: cal_start, then hold Wr=100/Wj=-50 constant from iq_comp model -> 2 cycles op_mode=00, then op_mode=01, freeze=1 after 256 stable cycles, Wr_store=100, Wj_store=-50, op_mode=10, cal_done=1.
- Threshold edge: Wr steps by exactly 8 every cycle -> counted stable, converges. Wr steps by 9 -> stable_cnt resets; cal_fail=1 after 40000 ADAPT cycles, op_mode=00.
- Wrap/extremes: Wr alternates 4095/-4096 -> delta computed at 14 bits, not stable, no false convergence.
- Abort: cal_abort during ADAPT at adapt_cnt=500, with stores previously 20/30 -> IDLE next cycle, op_mode=00, stores still 20/30. Simultaneous cal_start+cal_abort in IDLE -> stays IDLE.
- Direct load: load_w with w_load_r=-7, w_load_j=12 in IDLE -> stores=-7/12, then op_mode=10, cal_done=1. load_w during ADAPT -> ignored.
